// File: rtl/pulse_to_handshake_if.sv
// Bundle of the pulse input, the 4-phase req/ack pair and the status outputs
// of pulse_to_handshake. The slave view belongs to the converter; the master
// view belongs to whatever drives the pulses and consumes the requests.
interface pulse_to_handshake_if #(
   parameter int PEND_W = 2
);
   logic              pulse;
   logic              ack;
   logic              clear_flags;
   logic              req;
   logic              busy;
   logic              done;
   logic [PEND_W-1:0] pending;
   logic              overflow;
   logic              proto_err;

   modport master (
      output pulse, ack, clear_flags,
      input  req, busy, done, pending, overflow, proto_err
   );

   modport slave (
      input  pulse, ack, clear_flags,
      output req, busy, done, pending, overflow, proto_err
   );
endinterface

// File: rtl/pulse_to_handshake.sv
// Converts single-cycle load pulses into 4-phase req/ack handshakes.
// Pulses arriving while a handshake is already in progress are counted and
// replayed later. When the counter is full, further pulses are dropped and
// flagged in a sticky overflow bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transaction; req low; may start from pulse or backlog
// HOLD     | req high for HOLD_CYCLES cycles, ack ignored
// WAIT_ACK | req high, waiting for the consumer to raise ack
// WAIT_LOW | req low, waiting for the consumer to drop ack
module pulse_to_handshake #(
   parameter int HOLD_CYCLES = 4,
   parameter int PEND_W      = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   pulse_to_handshake_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      WAIT_ACK = 2'd2,
      WAIT_LOW = 2'd3
   } state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              req_q, req_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic              perr_q, perr_d;

   logic              idle;
   logic              start;
   logic              pend_inc;
   logic              pend_dec;
   logic              drop;

   // Event bookkeeping: a pulse starts a transaction directly only when the
   // block is idle with an empty backlog; every other pulse joins the backlog.
   always_comb begin
      idle     = (state_q == IDLE);
      pend_dec = idle && (pend_q != '0);
      start    = pend_dec || (idle && bus.pulse);
      pend_inc = bus.pulse && !(idle && (pend_q == '0));
      drop     = pend_inc && !pend_dec && (&pend_q);
   end

   // State register and hold counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; the hold counter counts down to zero before ack is looked at.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (cnt_q == 8'd0) state_d = WAIT_ACK;
            else               cnt_d   = cnt_q - 8'd1;
         end
         WAIT_ACK: begin
            if (bus.ack) state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!bus.ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the next state so every output comes straight from a flop.
   always_comb begin
      req_d  = (state_d == HOLD) || (state_d == WAIT_ACK);
      busy_d = (state_d != IDLE);
      done_d = (state_q == WAIT_LOW) && (state_d == IDLE);

      pend_d = pend_q;
      if (pend_inc && !pend_dec) begin
         if (!drop) pend_d = pend_q + PEND_W'(1);
      end else if (pend_dec && !pend_inc) begin
         pend_d = pend_q - PEND_W'(1);
      end

      // A set in the same cycle as a clear wins.
      if (drop)                 ovf_d = 1'b1;
      else if (bus.clear_flags) ovf_d = 1'b0;
      else                      ovf_d = ovf_q;

      if (idle && bus.ack)      perr_d = 1'b1;
      else if (bus.clear_flags) perr_d = 1'b0;
      else                      perr_d = perr_q;
   end

   // Registered outputs, backlog counter and sticky flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pend_q <= '0;
         ovf_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         req_q  <= req_d;
         busy_q <= busy_d;
         done_q <= done_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         perr_q <= perr_d;
      end
   end

   assign bus.req       = req_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pending   = pend_q;
   assign bus.overflow  = ovf_q;
   assign bus.proto_err = perr_q;

endmodule

// File: doc/pulse_to_handshake.md
PULSE_TO_HANDSHAKE -- requirements
Module: pulse_to_handshake

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, setting the minimum number of cycles req is held high before ack is examined (legal range 1..255).
REQ-002 The block SHALL have parameter PEND_W, default 2, setting the width of the pending-pulse counter (maximum pending count 2^PEND_W-1).
REQ-003 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port pulse, input, 1 bit: single-cycle load pulse from the upstream pulse generator; each high cycle is one event.
REQ-006 Port ack, input, 1 bit: level acknowledge from the downstream consumer (4-phase handshake).
REQ-007 Port clear_flags, input, 1 bit: synchronous clear of the sticky error flags.
REQ-008 Port req, output, 1 bit: registered level request to the consumer.
REQ-009 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 Port done, output, 1 bit: one-cycle pulse on completion of a handshake.
REQ-011 Port pending, output, PEND_W bits: count of accepted but not yet started events.
REQ-012 Port overflow, output, 1 bit: sticky flag; an event was dropped.
REQ-013 Port proto_err, output, 1 bit: sticky flag; ack was high while IDLE.

Function
REQ-014 The state machine SHALL have four states: IDLE, HOLD, WAIT_ACK, WAIT_LOW. All outputs SHALL be registered.
REQ-015 IDLE: req=0. If pending>0, or pulse=1 with pending=0, the next state SHALL be HOLD, with req=1 from the next cycle and the hold counter loaded with HOLD_CYCLES-1.
REQ-016 Latency SHALL be one cycle: req rises in the cycle after the edge that sampled pulse=1 in IDLE with pending=0.
REQ-017 HOLD: req=1, the counter decrements each cycle, and ack is ignored. When the counter=0, the next state SHALL be WAIT_ACK, so HOLD lasts exactly HOLD_CYCLES cycles.
REQ-018 WAIT_ACK: req=1. ack=1 SHALL give the next state WAIT_LOW with req=0 from the next cycle. ack=0 SHALL keep the state, with no timeout.
REQ-019 WAIT_LOW: req=0. ack=0 SHALL give the next state IDLE and done=1 for exactly that following cycle. ack=1 SHALL keep the state.
REQ-020 A pulse=1 accepted while not starting directly from IDLE with pending=0 SHALL increment pending; this covers the busy case and IDLE with pending>0.
REQ-021 Starting a transaction from IDLE with pending>0 SHALL decrement pending.
REQ-022 If pending is incremented and decremented in the same cycle, pending SHALL stay unchanged and overflow SHALL NOT be set.
REQ-023 A pulse arriving when pending=2^PEND_W-1 and no decrement occurs that cycle SHALL be dropped, leave pending unchanged and set overflow.
REQ-024 ack=1 sampled in IDLE SHALL set proto_err, with no state change.
REQ-025 clear_flags=1 SHALL clear overflow and proto_err on the next edge. If a set condition occurs in the same cycle, the set SHALL take priority.
REQ-026 Consecutive pending transactions SHALL be separated by at least one IDLE cycle: done cycle first, then req rises one cycle later.
REQ-027 pending SHALL never wrap, neither above its maximum nor below 0.

Reset
REQ-028 While reset_n=0, the state SHALL be IDLE and req, busy, done, overflow, proto_err, pending and the hold counter SHALL all be 0, asynchronously.
REQ-029 Reset asserted mid-handshake SHALL abort it with no done pulse and discard all pending events.
REQ-030 After reset_n deasserts, a pulse sampled on the first active edge SHALL be honoured per REQ-016.

Verification
REQ-031 Basic handshake, HOLD_CYCLES=4: pulse at cycle 0, ack=1 at cycle 2, ack=0 at cycle 8 -> req=1 for cycles 1-5, req=0 at cycle 6, done=1 at cycle 9 only, busy for cycles 1-8.
REQ-032 Queuing, PEND_W=2: 5 pulses during one busy transaction -> pending reaches 3, overflow=1 after the 4th queued pulse, and exactly 3 further handshakes complete.
REQ-033 Simultaneous events: pulse=1 in the same cycle IDLE starts from pending=2 -> pending stays 2, overflow=0.
REQ-034 Errors: ack=1 in IDLE -> proto_err=1 and sticky; clear_flags pulsed -> both flags 0 the next cycle; clear_flags together with a new overflow event -> overflow stays 1.
REQ-035 Reset mid-operation: reset_n low during WAIT_ACK with pending=2 -> req=0, pending=0, busy=0 immediately, no done, and no handshake after release.
REQ-036 HOLD_CYCLES=1 with ack already high during HOLD -> req high exactly 2 cycles (HOLD, WAIT_ACK), then WAIT_LOW.
